// File: rtl/unidad_control_pkg.sv
// Opcode map, per-stage control bundles and the combinational opcode decoder
// shared by the pipelined vector control unit.
package unidad_control_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_VADD = 4'h1;
  localparam logic [3:0] OP_VSUB = 4'h2;
  localparam logic [3:0] OP_VLD  = 4'h3;
  localparam logic [3:0] OP_VST  = 4'h4;
  localparam logic [3:0] OP_VRED = 4'h5;
  localparam logic [3:0] OP_VMUL = 4'h6;
  localparam logic [3:0] OP_VAND = 4'h7;
  localparam logic [3:0] OP_VOR  = 4'h8;
  localparam logic [3:0] OP_VXOR = 4'h9;
  localparam logic [3:0] OP_VMAX = 4'hA;
  localparam logic [3:0] OP_VMIN = 4'hB;
  localparam logic [3:0] OP_SLI  = 4'hC;
  localparam logic [3:0] OP_SADD = 4'hD;
  localparam logic [3:0] OP_VMOV = 4'hE;
  localparam logic [3:0] OP_STRM = 4'hF;

  typedef struct packed {
    logic sel_op;
    logic sel_ad;
    logic sel_int;
  } ex_ctrl_t;

  typedef struct packed {
    logic sum_mem;
    logic sel_mem;
    logic sel_data;
    logic mem_wr;
  } mem_ctrl_t;

  typedef struct packed {
    logic sel_wb;
    logic reg_wrv;
    logic reg_wrs;
  } wb_ctrl_t;

  // Fourteen control fields: four consumed in ID, the rest ride the pipeline.
  typedef struct packed {
    logic      sel_pc;
    logic      reg_rdv;
    logic      reg_rds;
    logic      sel_dest;
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_VADD, OP_VSUB: begin
        c.reg_rdv    = 1'b1;
        c.wb.sel_wb  = 1'b1;
        c.wb.reg_wrv = 1'b1;
      end
      OP_VLD: begin
        c.sel_dest     = 1'b1;
        c.reg_rdv      = 1'b1;
        c.mem.sel_mem  = 1'b1;
        c.mem.sel_data = 1'b1;
        c.wb.reg_wrv   = 1'b1;
      end
      OP_VST: begin
        c.sel_dest     = 1'b1;
        c.reg_rdv      = 1'b1;
        c.mem.sel_mem  = 1'b1;
        c.mem.sel_data = 1'b1;
        c.mem.mem_wr   = 1'b1;
      end
      OP_VRED, OP_VMAX, OP_VMIN: begin
        c.reg_rdv    = 1'b1;
        c.reg_rds    = 1'b1;
        c.ex.sel_int = 1'b1;
        c.wb.sel_wb  = 1'b1;
      end
      OP_VMUL, OP_VAND, OP_VOR, OP_VXOR: begin
        c.reg_rdv    = 1'b1;
        c.reg_rds    = 1'b1;
        c.ex.sel_int = 1'b1;
        c.ex.sel_op  = 1'b1;
        c.wb.sel_wb  = 1'b1;
      end
      OP_SLI: begin
        c.sel_dest   = 1'b1;
        c.wb.sel_wb  = 1'b1;
        c.wb.reg_wrs = 1'b1;
      end
      OP_SADD: begin
        c.reg_rds    = 1'b1;
        c.ex.sel_ad  = 1'b1;
        c.wb.sel_wb  = 1'b1;
        c.wb.reg_wrs = 1'b1;
      end
      OP_VMOV: begin
        c.sel_dest     = 1'b1;
        c.reg_rdv      = 1'b1;
        c.mem.sel_data = 1'b1;
        c.wb.reg_wrv   = 1'b1;
      end
      OP_STRM: begin
        c.sel_pc       = 1'b1;
        c.sel_dest     = 1'b1;
        c.reg_rdv      = 1'b1;
        c.mem.sum_mem  = 1'b1;
        c.mem.sel_data = 1'b1;
        c.mem.mem_wr   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidad_control_pipe_beat.sv
// Beat sequencer: counts the beats of a vector op sitting in ID and holds
// fetch until the final beat issues.
module vec_beat_seq #(
  parameter int  BEATS  = 2,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  input  logic              vector_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [BEAT_W-1:0] beat_o,
  output logic              fetch_hold_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  // Stall outranks flush; a flush only lands on an unstalled edge.
  always_comb begin
    beat_d = beat_q;
    if (!stall_i) begin
      if (flush_i) begin
        beat_d = '0;
      end else if (instr_valid_i && vector_i) begin
        beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_o       = instr_valid_i ? beat_q : '0;
  assign fetch_hold_o = stall_i | (instr_valid_i & vector_i & ~last_beat);

endmodule

// File: rtl/unidad_control_pipe.sv
// Pipelined control unit: decodes in ID and carries control bundles with
// valid bits and beat tags through EX, MEM and WB.
module unidad_control_pipe
  import unidad_control_pkg::*;
#(
  parameter int  VLEN   = 8,
  parameter int  LANES  = 4,
  localparam int BEATS  = VLEN / LANES,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [3:0]        opcode_in,
  input  logic              stall,
  input  logic              flush,
  output logic              fetch_hold,
  output logic              sel_pc,
  output logic              reg_rdv,
  output logic              reg_rds,
  output logic              sel_dest,
  output logic [BEAT_W-1:0] id_beat,
  output logic              ex_valid,
  output logic              ex_sel_op,
  output logic              ex_sel_ad,
  output logic              ex_sel_int,
  output logic [3:0]        ex_opcode,
  output logic [BEAT_W-1:0] ex_beat,
  output logic              mem_valid,
  output logic              mem_sum_mem,
  output logic              mem_sel_mem,
  output logic              mem_sel_data,
  output logic              mem_wr,
  output logic [BEAT_W-1:0] mem_beat,
  output logic              wb_valid,
  output logic              wb_sel_wb,
  output logic              wb_reg_wrv,
  output logic              wb_reg_wrs,
  output logic [BEAT_W-1:0] wb_beat
);

  ctrl_t id_ctrl;

  assign id_ctrl = instr_valid ? decode(opcode_in) : '0;

  vec_beat_seq #(.BEATS(BEATS)) u_beat_seq (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid),
    .vector_i      (id_ctrl.reg_rdv),
    .stall_i       (stall),
    .flush_i       (flush),
    .beat_o        (id_beat),
    .fetch_hold_o  (fetch_hold)
  );

  logic              ex_valid_q,  ex_valid_d;
  logic [3:0]        ex_opcode_q, ex_opcode_d;
  logic [BEAT_W-1:0] ex_beat_q,   ex_beat_d;
  ex_ctrl_t          ex_ex_q,     ex_ex_d;
  mem_ctrl_t         ex_mem_q,    ex_mem_d;
  wb_ctrl_t          ex_wb_q,     ex_wb_d;

  logic              mem_valid_q, mem_valid_d;
  logic [BEAT_W-1:0] mem_beat_q,  mem_beat_d;
  mem_ctrl_t         mem_mem_q,   mem_mem_d;
  wb_ctrl_t          mem_wb_q,    mem_wb_d;

  logic              wb_valid_q,  wb_valid_d;
  logic [BEAT_W-1:0] wb_beat_q,   wb_beat_d;
  wb_ctrl_t          wb_wb_q,     wb_wb_d;

  // Fields are zeroed whenever a stage's valid drops, so bubbles read all-zero.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_opcode_d = ex_opcode_q;
    ex_beat_d   = ex_beat_q;
    ex_ex_d     = ex_ex_q;
    ex_mem_d    = ex_mem_q;
    ex_wb_d     = ex_wb_q;
    mem_valid_d = mem_valid_q;
    mem_beat_d  = mem_beat_q;
    mem_mem_d   = mem_mem_q;
    mem_wb_d    = mem_wb_q;
    wb_valid_d  = wb_valid_q;
    wb_beat_d   = wb_beat_q;
    wb_wb_d     = wb_wb_q;
    if (!stall) begin
      ex_valid_d  = instr_valid & ~flush;
      ex_opcode_d = ex_valid_d ? opcode_in   : '0;
      ex_beat_d   = ex_valid_d ? id_beat     : '0;
      ex_ex_d     = ex_valid_d ? id_ctrl.ex  : '0;
      ex_mem_d    = ex_valid_d ? id_ctrl.mem : '0;
      ex_wb_d     = ex_valid_d ? id_ctrl.wb  : '0;

      mem_valid_d = ex_valid_q & ~flush;
      mem_beat_d  = mem_valid_d ? ex_beat_q : '0;
      mem_mem_d   = mem_valid_d ? ex_mem_q  : '0;
      mem_wb_d    = mem_valid_d ? ex_wb_q   : '0;

      wb_valid_d  = mem_valid_q;
      wb_beat_d   = mem_beat_q;
      wb_wb_d     = mem_wb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= '0;
      ex_beat_q   <= '0;
      ex_ex_q     <= '0;
      ex_mem_q    <= '0;
      ex_wb_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_beat_q  <= '0;
      mem_mem_q   <= '0;
      mem_wb_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_beat_q   <= '0;
      wb_wb_q     <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_opcode_q <= ex_opcode_d;
      ex_beat_q   <= ex_beat_d;
      ex_ex_q     <= ex_ex_d;
      ex_mem_q    <= ex_mem_d;
      ex_wb_q     <= ex_wb_d;
      mem_valid_q <= mem_valid_d;
      mem_beat_q  <= mem_beat_d;
      mem_mem_q   <= mem_mem_d;
      mem_wb_q    <= mem_wb_d;
      wb_valid_q  <= wb_valid_d;
      wb_beat_q   <= wb_beat_d;
      wb_wb_q     <= wb_wb_d;
    end
  end

  assign sel_pc       = id_ctrl.sel_pc;
  assign reg_rdv      = id_ctrl.reg_rdv;
  assign reg_rds      = id_ctrl.reg_rds;
  assign sel_dest     = id_ctrl.sel_dest;

  assign ex_valid     = ex_valid_q;
  assign ex_sel_op    = ex_ex_q.sel_op;
  assign ex_sel_ad    = ex_ex_q.sel_ad;
  assign ex_sel_int   = ex_ex_q.sel_int;
  assign ex_opcode    = ex_opcode_q;
  assign ex_beat      = ex_beat_q;

  assign mem_valid    = mem_valid_q;
  assign mem_sum_mem  = mem_mem_q.sum_mem;
  assign mem_sel_mem  = mem_mem_q.sel_mem;
  assign mem_sel_data = mem_mem_q.sel_data;
  assign mem_wr       = mem_mem_q.mem_wr;
  assign mem_beat     = mem_beat_q;

  assign wb_valid     = wb_valid_q;
  assign wb_sel_wb    = wb_wb_q.sel_wb;
  assign wb_reg_wrv   = wb_wb_q.reg_wrv;
  assign wb_reg_wrs   = wb_wb_q.reg_wrs;
  assign wb_beat      = wb_beat_q;

endmodule

// File: tb/tb_unidad_control_pipe.sv
// Directed bench for unidad_control_pipe with VLEN=8, LANES=4 (two beats per
// vector op); expected values are hand-derived from the pipeline timing.
module tb_unidad_control_pipe;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] opcode_in;
  logic       stall;
  logic       flush;
  logic       fetch_hold;
  logic       sel_pc, reg_rdv, reg_rds, sel_dest;
  logic [0:0] id_beat;
  logic       ex_valid, ex_sel_op, ex_sel_ad, ex_sel_int;
  logic [3:0] ex_opcode;
  logic [0:0] ex_beat;
  logic       mem_valid, mem_sum_mem, mem_sel_mem, mem_sel_data, mem_wr;
  logic [0:0] mem_beat;
  logic       wb_valid, wb_sel_wb, wb_reg_wrv, wb_reg_wrs;
  logic [0:0] wb_beat;

  int n_assert = 0;
  int n_fail   = 0;

  unidad_control_pipe #(.VLEN(8), .LANES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .opcode_in    (opcode_in),
    .stall        (stall),
    .flush        (flush),
    .fetch_hold   (fetch_hold),
    .sel_pc       (sel_pc),
    .reg_rdv      (reg_rdv),
    .reg_rds      (reg_rds),
    .sel_dest     (sel_dest),
    .id_beat      (id_beat),
    .ex_valid     (ex_valid),
    .ex_sel_op    (ex_sel_op),
    .ex_sel_ad    (ex_sel_ad),
    .ex_sel_int   (ex_sel_int),
    .ex_opcode    (ex_opcode),
    .ex_beat      (ex_beat),
    .mem_valid    (mem_valid),
    .mem_sum_mem  (mem_sum_mem),
    .mem_sel_mem  (mem_sel_mem),
    .mem_sel_data (mem_sel_data),
    .mem_wr       (mem_wr),
    .mem_beat     (mem_beat),
    .wb_valid     (wb_valid),
    .wb_sel_wb    (wb_sel_wb),
    .wb_reg_wrv   (wb_reg_wrv),
    .wb_reg_wrs   (wb_reg_wrs),
    .wb_beat      (wb_beat)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [3:0] op,
                       input logic st, input logic fl);
    instr_valid = iv;
    opcode_in   = op;
    stall       = st;
    flush       = fl;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #2;
    chk("rst_ex_valid",   8'(ex_valid),   8'h0);
    chk("rst_mem_valid",  8'(mem_valid),  8'h0);
    chk("rst_wb_valid",   8'(wb_valid),   8'h0);
    chk("rst_fetch_hold", 8'(fetch_hold), 8'h0);
    chk("rst_mem_wr",     8'(mem_wr),     8'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    #2;
    chk("rel_fetch_hold", 8'(fetch_hold), 8'h0);
    chk("rel_id_beat",    8'(id_beat),    8'h0);

    // Opcode 1, two beats
    cyc(); drive(1'b1, 4'h1, 1'b0, 1'b0); #2;
    chk("a0_fetch_hold", 8'(fetch_hold), 8'h1);
    chk("a0_id_beat",    8'(id_beat),    8'h0);
    chk("a0_reg_rdv",    8'(reg_rdv),    8'h1);
    chk("a0_sel_dest",   8'(sel_dest),   8'h0);
    cyc(); #2;
    chk("a1_fetch_hold", 8'(fetch_hold), 8'h0);
    chk("a1_id_beat",    8'(id_beat),    8'h1);
    chk("a1_ex_valid",   8'(ex_valid),   8'h1);
    chk("a1_ex_beat",    8'(ex_beat),    8'h0);
    cyc(); drive(1'b0, 4'h0, 1'b0, 1'b0); #2;
    chk("a2_ex_valid",   8'(ex_valid),   8'h1);
    chk("a2_ex_beat",    8'(ex_beat),    8'h1);
    chk("a2_mem_valid",  8'(mem_valid),  8'h1);
    chk("a2_mem_beat",   8'(mem_beat),   8'h0);
    chk("a2_id_beat",    8'(id_beat),    8'h0);
    cyc(); #2;
    chk("a3_ex_valid",   8'(ex_valid),   8'h0);
    chk("a3_wb_valid",   8'(wb_valid),   8'h1);
    chk("a3_wb_reg_wrv", 8'(wb_reg_wrv), 8'h1);
    chk("a3_wb_beat",    8'(wb_beat),    8'h0);
    cyc(); #2;
    chk("a4_wb_reg_wrv", 8'(wb_reg_wrv), 8'h1);
    chk("a4_wb_beat",    8'(wb_beat),    8'h1);
    cyc(); #2;
    chk("a5_wb_reg_wrv", 8'(wb_reg_wrv), 8'h0);
    chk("a5_wb_valid",   8'(wb_valid),   8'h0);

    // Opcode D, scalar single beat
    cyc(); drive(1'b1, 4'hD, 1'b0, 1'b0); #2;
    chk("b0_fetch_hold", 8'(fetch_hold), 8'h0);
    chk("b0_reg_rds",    8'(reg_rds),    8'h1);
    chk("b0_reg_rdv",    8'(reg_rdv),    8'h0);
    cyc(); drive(1'b0, 4'h0, 1'b0, 1'b0); #2;
    chk("b1_ex_valid",   8'(ex_valid),   8'h1);
    chk("b1_ex_sel_ad",  8'(ex_sel_ad),  8'h1);
    chk("b1_ex_sel_int", 8'(ex_sel_int), 8'h0);
    chk("b1_ex_opcode",  8'(ex_opcode),  8'h0D);
    cyc(); #2;
    chk("b2_mem_valid",  8'(mem_valid),  8'h1);
    chk("b2_wb_reg_wrs", 8'(wb_reg_wrs), 8'h0);
    cyc(); #2;
    chk("b3_wb_reg_wrs", 8'(wb_reg_wrs), 8'h1);
    chk("b3_wb_sel_wb",  8'(wb_sel_wb),  8'h1);
    cyc(); #2;
    chk("b4_wb_reg_wrs", 8'(wb_reg_wrs), 8'h0);

    // Opcode 4 with a three-cycle stall on beat 0, then a stall mid-pipe
    cyc(); drive(1'b1, 4'h4, 1'b1, 1'b0); #2;
    chk("c0_fetch_hold", 8'(fetch_hold), 8'h1);
    chk("c0_id_beat",    8'(id_beat),    8'h0);
    chk("c0_ex_valid",   8'(ex_valid),   8'h0);
    cyc(); #2;
    chk("c1_fetch_hold", 8'(fetch_hold), 8'h1);
    chk("c1_id_beat",    8'(id_beat),    8'h0);
    chk("c1_ex_valid",   8'(ex_valid),   8'h0);
    cyc(); #2;
    chk("c2_fetch_hold", 8'(fetch_hold), 8'h1);
    chk("c2_id_beat",    8'(id_beat),    8'h0);
    chk("c2_ex_valid",   8'(ex_valid),   8'h0);
    cyc(); drive(1'b1, 4'h4, 1'b0, 1'b0); #2;
    chk("c3_fetch_hold", 8'(fetch_hold), 8'h1);
    chk("c3_id_beat",    8'(id_beat),    8'h0);
    chk("c3_ex_valid",   8'(ex_valid),   8'h0);
    cyc(); #2;
    chk("c4_fetch_hold", 8'(fetch_hold), 8'h0);
    chk("c4_id_beat",    8'(id_beat),    8'h1);
    chk("c4_ex_valid",   8'(ex_valid),   8'h1);
    chk("c4_ex_beat",    8'(ex_beat),    8'h0);
    chk("c4_mem_wr",     8'(mem_wr),     8'h0);
    cyc(); drive(1'b0, 4'h0, 1'b1, 1'b0); #2;
    chk("c5_mem_wr",     8'(mem_wr),     8'h1);
    chk("c5_mem_beat",   8'(mem_beat),   8'h0);
    chk("c5_ex_beat",    8'(ex_beat),    8'h1);
    chk("c5_fetch_hold", 8'(fetch_hold), 8'h1);
    cyc(); drive(1'b0, 4'h0, 1'b0, 1'b0); #2;
    chk("c6_mem_wr",     8'(mem_wr),     8'h1);
    chk("c6_mem_beat",   8'(mem_beat),   8'h0);
    chk("c6_ex_valid",   8'(ex_valid),   8'h1);
    chk("c6_ex_beat",    8'(ex_beat),    8'h1);
    cyc(); #2;
    chk("c7_mem_wr",     8'(mem_wr),     8'h1);
    chk("c7_mem_beat",   8'(mem_beat),   8'h1);
    chk("c7_mem_sel_mem", 8'(mem_sel_mem), 8'h1);
    chk("c7_ex_valid",   8'(ex_valid),   8'h0);
    cyc(); #2;
    chk("c8_mem_wr",     8'(mem_wr),     8'h0);
    chk("c8_mem_valid",  8'(mem_valid),  8'h0);

    // Opcode 3 flushed on beat 1, followed by a valid nop
    cyc(); drive(1'b1, 4'h3, 1'b0, 1'b0); #2;
    chk("d0_id_beat",    8'(id_beat),    8'h0);
    chk("d0_fetch_hold", 8'(fetch_hold), 8'h1);
    chk("d0_sel_dest",   8'(sel_dest),   8'h1);
    cyc(); drive(1'b1, 4'h3, 1'b0, 1'b1); #2;
    chk("d1_id_beat",    8'(id_beat),    8'h1);
    chk("d1_ex_valid",   8'(ex_valid),   8'h1);
    chk("d1_ex_beat",    8'(ex_beat),    8'h0);
    cyc(); drive(1'b1, 4'h0, 1'b0, 1'b0); #2;
    chk("d2_ex_valid",   8'(ex_valid),   8'h0);
    chk("d2_mem_valid",  8'(mem_valid),  8'h0);
    chk("d2_id_beat",    8'(id_beat),    8'h0);
    chk("d2_fetch_hold", 8'(fetch_hold), 8'h0);
    cyc(); drive(1'b0, 4'h0, 1'b0, 1'b0); #2;
    chk("d3_wb_reg_wrv", 8'(wb_reg_wrv), 8'h0);
    chk("d3_wb_valid",   8'(wb_valid),   8'h0);
    chk("d3_ex_valid",   8'(ex_valid),   8'h1);
    chk("d3_ex_sel_op",  8'(ex_sel_op),  8'h0);
    cyc(); #2;
    chk("d4_wb_reg_wrv", 8'(wb_reg_wrv), 8'h0);
    cyc(); #2;
    chk("d5_wb_reg_wrv", 8'(wb_reg_wrv), 8'h0);
    chk("d5_wb_valid",   8'(wb_valid),   8'h1);

    // Opcode F through to MEM
    cyc(); drive(1'b1, 4'hF, 1'b0, 1'b0); #2;
    chk("e0_sel_pc",     8'(sel_pc),     8'h1);
    chk("e0_fetch_hold", 8'(fetch_hold), 8'h1);
    chk("e0_sel_dest",   8'(sel_dest),   8'h1);
    cyc(); #2;
    chk("e1_id_beat",    8'(id_beat),    8'h1);
    chk("e1_ex_valid",   8'(ex_valid),   8'h1);
    cyc(); drive(1'b0, 4'h0, 1'b0, 1'b0); #2;
    chk("e2_mem_sum_mem", 8'(mem_sum_mem), 8'h1);
    chk("e2_mem_wr",     8'(mem_wr),     8'h1);
    chk("e2_mem_beat",   8'(mem_beat),   8'h0);
    chk("e2_mem_sel_data", 8'(mem_sel_data), 8'h1);
    cyc(); #2;
    chk("e3_mem_sum_mem", 8'(mem_sum_mem), 8'h1);
    chk("e3_mem_wr",     8'(mem_wr),     8'h1);
    chk("e3_mem_beat",   8'(mem_beat),   8'h1);
    cyc(); #2;
    chk("e4_mem_wr",     8'(mem_wr),     8'h0);

    // Opcode F cut short by an asynchronous reset pulse at t+1
    cyc(); drive(1'b1, 4'hF, 1'b0, 1'b0); #2;
    chk("r0_sel_pc",     8'(sel_pc),     8'h1);
    cyc(); #2;
    chk("r1_ex_valid",   8'(ex_valid),   8'h1);
    chk("r1_id_beat",    8'(id_beat),    8'h1);
    rst_n = 1'b0;
    #1;
    chk("r1_rst_ex_valid",  8'(ex_valid),  8'h0);
    chk("r1_rst_ex_opcode", 8'(ex_opcode), 8'h0);
    chk("r1_rst_mem_valid", 8'(mem_valid), 8'h0);
    chk("r1_rst_wb_valid",  8'(wb_valid),  8'h0);
    chk("r1_rst_id_beat",   8'(id_beat),   8'h0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    chk("r1_rst_fetch_hold", 8'(fetch_hold), 8'h0);
    cyc(); rst_n = 1'b1; #2;
    chk("r2_mem_wr",     8'(mem_wr),     8'h0);
    chk("r2_fetch_hold", 8'(fetch_hold), 8'h0);
    cyc(); #2;
    chk("r3_mem_wr",     8'(mem_wr),     8'h0);
    cyc(); #2;
    chk("r4_mem_wr",     8'(mem_wr),     8'h0);
    chk("r4_wb_valid",   8'(wb_valid),   8'h0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/unidad_control_pipe.md
Name: unidad_control_pipe

Overview:
- Pipelined, parametrised successor to the single-cycle opcode decoder of the vector processor.
- Decodes the 4-bit opcode in ID and carries per-stage control bundles through EX/MEM/WB registers with valid bits.
- Supports stall and flush.
- Sequences vector instructions over multiple beats when VLEN exceeds the lane count, holding fetch until the last beat issues.

Parameters:
- VLEN, 8, vector length in elements.
- LANES, 4, elements processed per beat.
- BEATS, VLEN/LANES, derived (localparam), beats per vector op; VLEN%LANES must be 0.
- BEAT_W, max(1,$clog2(BEATS)), derived (localparam), beat index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  opcode_in holds a real instruction.
- opcode_in  in  4  instruction opcode.
- stall  in  1  freeze all state (memory busy).
- flush  in  1  kill ID and EX contents.
- fetch_hold  out  1  fetch must re-present the same opcode next cycle.
- sel_pc, reg_rdv, reg_rds, sel_dest  out  1 each  ID-stage controls (combinational from opcode_in).
- id_beat  out  BEAT_W  current beat in ID.
- ex_valid  out  1.
- ex_sel_op, ex_sel_ad, ex_sel_int  out  1 each.
- ex_opcode  out  4.
- ex_beat  out  BEAT_W.
- mem_valid  out  1.
- mem_sum_mem, mem_sel_mem, mem_sel_data, mem_wr  out  1 each.
- mem_beat  out  BEAT_W.
- wb_valid  out  1.
- wb_sel_wb, wb_reg_wrv, wb_reg_wrs  out  1 each.
- wb_beat  out  BEAT_W.

Behaviour:
- Decode table. Any field not named is 0.
  - 0: nop, all controls 0.
  - 1, 2: reg_rdv, sel_wb, reg_wrv.
  - 3: sel_dest, reg_rdv, sel_mem, sel_data, reg_wrv.
  - 4: sel_dest, reg_rdv, sel_mem, sel_data, mem_wr.
  - 5, A, B: reg_rdv, reg_rds, sel_int, sel_wb.
  - 6–9: as 5, plus sel_op.
  - C: sel_dest, sel_wb, reg_wrs.
  - D: reg_rds, sel_ad, sel_wb, reg_wrs.
  - E: sel_dest, reg_rdv, sel_data, reg_wrv.
  - F: sel_pc, sel_dest, reg_rdv, sum_mem, sel_data, mem_wr.
- ID outputs when instr_valid=0: all ID controls 0; id_beat=0.
- Multi-beat rule: opcodes with reg_rdv=1 are vector ops and take BEATS beats; all others take 1 beat.
- Beat counter (state):
  - Reset value 0.
  - Advances on each cycle with instr_valid & vector & ~stall & ~flush.
  - Wraps to 0 after BEATS-1.
  - Held while stall=1.
  - Cleared to 0 on flush.
- fetch_hold = instr_valid & vector & (beat != BEATS-1). Forced to 1 while stall=1.
- When BEATS=1, fetch_hold is 0 except during stall.
- Stage advance, on each clk edge with stall=0:
  - ID→EX: valid ← instr_valid & ~flush.
  - EX→MEM: valid ← ex_valid & ~flush.
  - MEM→WB: normal advance.
  - Each stage's fields and beat copy from the previous stage.
- When a stage's valid=0, all its control fields and beat read 0 (bubble).
- mem_wr, wb_reg_wrv and wb_reg_wrs can therefore never assert without their stage's valid.
- stall=1: every register holds its value, including valids, beats and the counter.
- Stall/flush precedence: stall has priority; flush during stall takes effect on the first non-stalled edge only if still asserted then.
- Latency: an instruction at ID in cycle t appears in EX at t+1, MEM at t+2, WB at t+3, with no stalls.
- Vector op timing: a vector op occupies ID for BEATS consecutive unstalled cycles and emits BEATS valid entries with beat 0..BEATS-1.
- Reset: all registered outputs, valids, beats and the counter are 0. Reset mid-sequence discards the in-flight beats.

Decomposition:
- Package unidad_control_pkg:
  - opcode localparams OP_NOP..OP_STRM;
  - packed struct ctrl_t with the 14 control fields;
  - function decode(opcode) returning ctrl_t.
- Sub-module vec_beat_seq: beat counter plus fetch_hold logic, parametrised by BEATS.
- The top module holds the decode function call and the three stage registers.

Test Plan (VLEN=8, LANES=4 → BEATS=2):
- Reset: assert rst_n=0 mid-clock → all outputs 0 immediately; fetch_hold=0 after release.
- Opcode 1, instr_valid held:
  - cycle0: fetch_hold=1, id_beat=0; cycle1: fetch_hold=0, id_beat=1.
  - ex_valid in cycles 1–2 with ex_beat 0,1.
  - wb_reg_wrv=1 in cycles 3–4.
- Opcode D, single cycle: fetch_hold=0, reg_rds=1.
  - ex_sel_ad=1 at t+1.
  - wb_reg_wrs=1 exactly one cycle at t+3.
- Opcode 4 with stall=1 for 3 cycles during beat 0:
  - all registers frozen, fetch_hold=1 throughout.
  - mem_wr high exactly 2 unstalled cycles in total, mem_beat 0 then 1.
- Opcode 3 at id_beat=1 with beat 0 in EX, pulse flush=1:
  - next cycle ex_valid=0 and mem_valid=0;
  - neither beat produces wb_reg_wrv;
  - id_beat=0.
- Opcode F:
  - sel_pc=1 in ID;
  - mem_sum_mem=1 and mem_wr=1 at t+2 and t+3;
  - rst_n pulse at t+1 → no mem_wr at any later cycle.
